// File: rtl/spi_master_2ss.sv
// SPI mode-0 master with two active-low slave selects and registered outputs.
// One transfer is SETUP, DATA_W bits of two CLK_DIV-cycle phases, then HOLD.
module spi_master_2ss #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              slave_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss1,
  output logic              ss2
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t            state;
  logic [7:0]        div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic              phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ss1     <= 1'b1;
      ss2     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SETUP;
            tx_sh   <= tx_data;
            mosi    <= tx_data[DATA_W-1];
            busy    <= 1'b1;
            ss1     <= slave_sel;
            ss2     <= ~slave_sel;
            div_cnt <= '0;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end
        end
        SETUP: begin
          div_cnt <= phase_end ? 8'd0 : div_cnt + 8'd1;
          if (phase_end) state <= XFER;
        end
        XFER: begin
          // The divider counts one half-period; sclk itself tells which half.
          div_cnt <= phase_end ? 8'd0 : div_cnt + 8'd1;
          if (phase_end) begin
            if (!sclk) begin
              sclk  <= 1'b1;
              rx_sh <= {rx_sh[DATA_W-2:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
                mosi    <= tx_sh[DATA_W-2];
              end
            end
          end
        end
        HOLD: begin
          div_cnt <= phase_end ? 8'd0 : div_cnt + 8'd1;
          if (phase_end) begin
            state   <= DONE;
            ss1     <= 1'b1;
            ss2     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_2ss.sv
// Directed bench for spi_master_2ss: table of 8-bit transfers plus reset,
// back-to-back and 16-bit/CLK_DIV=2 sequences.
module tb_spi_master_2ss;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, slave_sel = 0, miso;
  logic [7:0] tx_data = 0, rx_data;
  logic busy, done, sclk, mosi, ss1, ss2;
  logic lb = 1'b1;
  logic [7:0] slave_sh = 0;

  logic start16 = 0;
  logic [15:0] tx16 = 0, rx16;
  logic busy16, done16, sclk16, mosi16, ss1_16, ss2_16;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  assign miso = lb ? mosi : slave_sh[7];

  spi_master_2ss dut (
    .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss1(ss1), .ss2(ss2));

  spi_master_2ss #(.CLK_DIV(2), .DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .slave_sel(1'b0), .tx_data(tx16),
    .busy(busy16), .done(done16), .rx_data(rx16), .sclk(sclk16), .mosi(mosi16),
    .miso(mosi16), .ss1(ss1_16), .ss2(ss2_16));

  always @(negedge clk) if (!rst) begin
    assert (ss1 || ss2) else $error("both selects low");
    assert (!(ss1 && ss2 && sclk)) else $error("sclk high while deselected");
    assert (ss1_16 || ss2_16) else $error("both selects low (16)");
    assert (!(ss1_16 && ss2_16 && sclk16)) else $error("sclk high while deselected (16)");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] tx;
    logic [7:0] resp;
    logic       loopback;
    logic [7:0] exp_rx;
  } vec_t;

  int busy_cnt, sel_low, oth_low, pulses, dones;
  logic [7:0] mosi_bits;

  // Issue one transfer on the 8-bit DUT, scramble the inputs while busy, and
  // gather what was seen on the bus until done.
  task automatic run_xfer(input logic sel, input logic [7:0] tx, input logic [7:0] resp,
                          input logic lbk);
    logic prev_sclk;
    busy_cnt = 0; sel_low = 0; oth_low = 0; pulses = 0; dones = 0; mosi_bits = 0;
    @(negedge clk);
    lb = lbk; slave_sh = resp;
    start = 1; slave_sel = sel; tx_data = tx;
    @(negedge clk);
    start = 0; slave_sel = ~sel; tx_data = ~tx;
    prev_sclk = 0;
    for (int c = 0; c < 300 && dones == 0; c++) begin
      if (busy) busy_cnt++;
      if (!(sel ? ss2 : ss1)) sel_low++;
      if (!(sel ? ss1 : ss2)) oth_low++;
      if (sclk && !prev_sclk) begin pulses++; mosi_bits = {mosi_bits[6:0], mosi}; end
      if (!sclk && prev_sclk) slave_sh = {slave_sh[6:0], 1'b0};
      if (done) dones++;
      prev_sclk = sclk;
      @(negedge clk);
    end
    if (dones == 0) check("xfer_timeout", 0, 1);
    slave_sel = 0; tx_data = 0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 8'h3C, 8'hC3, 1'b0, 8'hC3};
    vecs[2] = '{1'b0, 8'h00, 8'hFF, 1'b0, 8'hFF};
    vecs[3] = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF};
    vecs[4] = '{1'b0, 8'h81, 8'h7E, 1'b0, 8'h7E};

    #12;
    check("rst_ss", {30'd0, ss1, ss2}, 32'h3);
    check("rst_outs", {28'd0, busy, done, sclk, mosi}, 32'h0);
    check("rst_rx", rx_data, 0);
    @(negedge clk) rst = 0;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].sel, vecs[i].tx, vecs[i].resp, vecs[i].loopback);
      check($sformatf("v%0d_rx", i), rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_busy", i), busy_cnt, 72);
      check($sformatf("v%0d_ss_low", i), sel_low, 72);
      check($sformatf("v%0d_other_ss", i), oth_low, 0);
      check($sformatf("v%0d_pulses", i), pulses, 8);
      check($sformatf("v%0d_mosi", i), mosi_bits, vecs[i].tx);
      @(negedge clk);
      check($sformatf("v%0d_done_once", i), {31'd0, done}, 0);
    end

    // start held across two transfers: second accepted after one idle cycle
    begin
      int accepts = 0, dn = 0, gap = 0;
      logic pb = 0;
      @(negedge clk);
      lb = 1; tx_data = 8'hFF; start = 1;
      for (int c = 0; c < 240; c++) begin
        @(negedge clk);
        if (c == 140) start = 0;
        if (busy && !pb) accepts++;
        if (done) dn++;
        if (accepts == 1 && dn == 1 && !busy && !done) gap++;
        pb = busy;
      end
      check("b2b_accepts", accepts, 2);
      check("b2b_dones", dn, 2);
      check("b2b_idle_gap", gap, 1);
      check("b2b_rx", rx_data, 8'hFF);
    end

    // reset during bit 4 aborts the transfer
    begin
      int rises = 0, dn = 0;
      logic ps = 0;
      @(negedge clk);
      lb = 1; tx_data = 8'h5A; slave_sel = 0; start = 1;
      @(negedge clk) start = 0;
      for (int c = 0; c < 200 && rises < 4; c++) begin
        if (sclk && !ps) rises++;
        ps = sclk;
        @(negedge clk);
      end
      check("rst_mid_reached", rises, 4);
      #2 rst = 1;
      #1;
      check("rst_mid_ss", {30'd0, ss1, ss2}, 32'h3);
      check("rst_mid_sclk_busy", {30'd0, sclk, busy}, 0);
      check("rst_mid_rx", rx_data, 0);
      @(negedge clk) rst = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (done) dn++;
      end
      check("rst_mid_no_done", dn, 0);
      check("rst_mid_idle", {31'd0, busy}, 0);
      run_xfer(1'b0, 8'h96, 8'h00, 1'b1);
      check("post_rst_rx", rx_data, 8'h96);
      check("post_rst_busy", busy_cnt, 72);
    end

    // 16-bit, CLK_DIV=2 loopback
    begin
      int bc = 0, dn = 0, r1 = -1, r2 = -1;
      logic ps = 0;
      @(negedge clk);
      tx16 = 16'h8001; start16 = 1;
      @(negedge clk);
      start16 = 0; tx16 = 16'h0000;
      for (int c = 0; c < 200 && dn == 0; c++) begin
        if (busy16) bc++;
        if (sclk16 && !ps) begin
          if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
        end
        if (done16) dn++;
        ps = sclk16;
        @(negedge clk);
      end
      check("w16_done", dn, 1);
      check("w16_busy", bc, 68);
      check("w16_sclk_period", r2 - r1, 4);
      check("w16_rx", rx16, 16'h8001);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
